// File: rtl/piano_pkg.sv
// Shared note encoding, recorder entry layout and recorder FSM states.
package piano_pkg;

    localparam int NOTE_W    = 4;
    localparam int DUR_W_DEF = 26;

    // Key code 0 is a rest; C..B follow chromatically.
    localparam logic [NOTE_W-1:0] KEY_REST = 4'd0;
    localparam logic [NOTE_W-1:0] KEY_C    = 4'd1;
    localparam logic [NOTE_W-1:0] KEY_CS   = 4'd2;
    localparam logic [NOTE_W-1:0] KEY_D    = 4'd3;
    localparam logic [NOTE_W-1:0] KEY_DS   = 4'd4;
    localparam logic [NOTE_W-1:0] KEY_E    = 4'd5;
    localparam logic [NOTE_W-1:0] KEY_F    = 4'd6;
    localparam logic [NOTE_W-1:0] KEY_FS   = 4'd7;
    localparam logic [NOTE_W-1:0] KEY_G    = 4'd8;
    localparam logic [NOTE_W-1:0] KEY_GS   = 4'd9;
    localparam logic [NOTE_W-1:0] KEY_A    = 4'd10;
    localparam logic [NOTE_W-1:0] KEY_AS   = 4'd11;
    localparam logic [NOTE_W-1:0] KEY_B    = 4'd12;

    typedef struct packed {
        logic [NOTE_W-1:0]    key;
        logic [DUR_W_DEF-1:0] hold;
        logic [DUR_W_DEF-1:0] period;
    } note_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLD,
        ST_GAP,
        ST_CAND
    } rec_state_t;

endpackage

// File: rtl/rec_mem.sv
// Note-entry storage: one write port, one registered read port (read-during-write returns old data).
module rec_mem #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 56
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents intentionally survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Records a live key_on/key stream as {key, hold, period} entries; glitch filter under SONG_REC_MIN_FILTER_EN.
// States: IDLE wait rec_en rise | ARMED wait first onset | HOLD note sounding | GAP note released | CAND new note not yet proven >= MIN_HOLD
module song_recorder
    import piano_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int DUR_W    = 26,
    parameter int MIN_HOLD = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rec_en,
    input  logic                     key_on,
    input  logic [NOTE_W-1:0]        key,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [NOTE_W-1:0]        rd_key,
    output logic [DUR_W-1:0]         rd_hold,
    output logic [DUR_W-1:0]         rd_period,
    output logic [$clog2(DEPTH):0]   note_count,
    output logic                     busy,
    output logic                     full,
    output logic                     commit
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [NOTE_W-1:0] key;
        logic [DUR_W-1:0]  hold;
        logic [DUR_W-1:0]  period;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam logic [DUR_W-1:0] CNT_MAX = '1;
    localparam longint unsigned PROMOTE_AT = (MIN_HOLD > 1) ? 64'(MIN_HOLD - 1) : 64'd0;

`ifdef SONG_REC_MIN_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    rec_state_t        state_q, state_d;
    logic              rec_en_q, key_on_q;
    logic [NOTE_W-1:0] key_q, key_d, cand_key_q, cand_key_d;
    logic [DUR_W-1:0]  hold_q, hold_d, cnt_q, cnt_d, cand_cnt_q, cand_cnt_d;
    logic [CW-1:0]     note_count_q, note_count_d, nc_inc;
    logic              commit_q;

    logic              rise, fall, onset, promote, wr_en;
    logic [DUR_W-1:0]  cnt_inc, cand_inc;
    entry_t            wr_entry, rd_entry;
    logic [ENTRY_W-1:0] rd_data;

    assign rise     = rec_en & ~rec_en_q;
    assign fall     = ~rec_en & rec_en_q;
    assign onset    = key_on & ~key_on_q;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DUR_W'(1);
    assign cand_inc = (cand_cnt_q == CNT_MAX) ? cand_cnt_q : cand_cnt_q + DUR_W'(1);
    assign nc_inc   = note_count_q + CW'(1);
    // Once the candidate is still held past MIN_HOLD-1 cycles its hold can no longer fall short.
    assign promote  = (64'(cand_cnt_q) >= PROMOTE_AT) || (cand_cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rec_en_q     <= 1'b0;
            key_on_q     <= 1'b0;
            key_q        <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            cand_key_q   <= '0;
            cand_cnt_q   <= '0;
            note_count_q <= '0;
            commit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_en_q     <= rec_en;
            key_on_q     <= key_on;
            key_q        <= key_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            cand_key_q   <= cand_key_d;
            cand_cnt_q   <= cand_cnt_d;
            note_count_q <= note_count_d;
            commit_q     <= wr_en;
        end
    end

    always_comb begin
        state_d         = state_q;
        key_d           = key_q;
        hold_d          = hold_q;
        cnt_d           = cnt_q;
        cand_key_d      = cand_key_q;
        cand_cnt_d      = cand_cnt_q;
        note_count_d    = note_count_q;
        wr_en           = 1'b0;
        wr_entry.key    = key_q;
        wr_entry.hold   = hold_q;
        wr_entry.period = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    note_count_d = '0;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (onset) begin
                    key_d   = key;
                    cnt_d   = DUR_W'(1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    wr_en         = 1'b1;
                    wr_entry.hold = cnt_q;
                    state_d       = ST_IDLE;
                end else if (!key_on) begin
                    hold_d  = cnt_q;
                    cnt_d   = cnt_inc;
                    state_d = ST_GAP;
                end else if (key != key_q) begin
                    if (FILTER_EN) begin
                        hold_d     = cnt_q;
                        cand_key_d = key;
                        cand_cnt_d = DUR_W'(1);
                        cnt_d      = cnt_inc;
                        state_d    = ST_CAND;
                    end else begin
                        wr_en         = 1'b1;
                        wr_entry.hold = cnt_q;
                        key_d         = key;
                        cnt_d         = DUR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_GAP: begin
                if (fall) begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end else if (onset) begin
                    if (FILTER_EN) begin
                        cand_key_d = key;
                        cand_cnt_d = DUR_W'(1);
                        cnt_d      = cnt_inc;
                        state_d    = ST_CAND;
                    end else begin
                        wr_en   = 1'b1;
                        key_d   = key;
                        cnt_d   = DUR_W'(1);
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CAND: begin
                // cnt keeps running the previous note's period; a discarded candidate folds into it.
                if (fall) begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!key_on) begin
                    cnt_d   = cnt_inc;
                    state_d = ST_GAP;
                end else if (key != cand_key_q) begin
                    cand_key_d = key;
                    cand_cnt_d = DUR_W'(1);
                    cnt_d      = cnt_inc;
                end else if (promote) begin
                    wr_en           = 1'b1;
                    wr_entry.period = cnt_q - cand_cnt_q;
                    key_d           = cand_key_q;
                    cnt_d           = cand_inc;
                    state_d         = ST_HOLD;
                end else begin
                    cnt_d      = cnt_inc;
                    cand_cnt_d = cand_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (wr_en) begin
            note_count_d = nc_inc;
            if (nc_inc == CW'(DEPTH)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        full       = (note_count_q == CW'(DEPTH));
        commit     = commit_q;
        note_count = note_count_q;
        rd_entry   = entry_t'(rd_data);
        rd_key     = rd_entry.key;
        rd_hold    = rd_entry.hold;
        rd_period  = rd_entry.period;
    end

    rec_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_rec_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (note_count_q[AW-1:0]),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: main instance (DEPTH=4, DUR_W=8) plus a narrow-counter instance (DUR_W=6).
module tb_song_recorder;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW_M  = 8;
    localparam int DW_S  = 6;
    localparam int MIN_H = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            rec_en, rec_en_s, key_on;
    logic [3:0]      key;
    logic [AW-1:0]   rd_addr   = '0;
    logic [AW-1:0]   rd_addr_s = '0;

    logic [3:0]      rd_key_m, rd_key_s;
    logic [DW_M-1:0] rd_hold_m, rd_period_m;
    logic [DW_S-1:0] rd_hold_s, rd_period_s;
    logic [AW:0]     note_count_m, note_count_s;
    logic            busy_m, full_m, commit_m, busy_s, full_s, commit_s;

    int errors = 0;
    int checks = 0;
    int commits_m = 0;

    typedef struct {
        logic [3:0] key;
        int         hold;
        int         period;
        int         idx;
    } exp_t;

    exp_t sb_m[$];
    exp_t sb_s[$];

    always #5 clk = ~clk;

    song_recorder #(.DEPTH(DEPTH), .DUR_W(DW_M), .MIN_HOLD(MIN_H)) u_dut (
        .clk(clk), .rst(rst), .rec_en(rec_en), .key_on(key_on), .key(key), .rd_addr(rd_addr),
        .rd_key(rd_key_m), .rd_hold(rd_hold_m), .rd_period(rd_period_m), .note_count(note_count_m),
        .busy(busy_m), .full(full_m), .commit(commit_m)
    );

    song_recorder #(.DEPTH(DEPTH), .DUR_W(DW_S), .MIN_HOLD(MIN_H)) u_sat (
        .clk(clk), .rst(rst), .rec_en(rec_en_s), .key_on(key_on), .key(key), .rd_addr(rd_addr_s),
        .rd_key(rd_key_s), .rd_hold(rd_hold_s), .rd_period(rd_period_s), .note_count(note_count_s),
        .busy(busy_s), .full(full_s), .commit(commit_s)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [3:0] k, input int on_c, input int off_c);
        key    = k;
        key_on = 1'b1;
        cyc(on_c);
        key_on = 1'b0;
        cyc(off_c);
    endtask

    task automatic push_m(input logic [3:0] k, input int h, input int p, input int i);
        exp_t e;
        e.key = k; e.hold = h; e.period = p; e.idx = i;
        sb_m.push_back(e);
    endtask

    task automatic start_rec();
        rec_en = 1'b1;
        #3;
        check("busy_before_rise_sampled", busy_m, 0);
        cyc(1);
        check("busy_after_rise", busy_m, 1);
        check("note_count_cleared", note_count_m, 0);
        check("full_cleared", full_m, 0);
        cyc(1);
    endtask

    task automatic end_test(input string name, input int n_exp, input int full_exp);
        cyc(6);
        check({name, "_note_count"}, note_count_m, n_exp);
        check({name, "_busy"}, busy_m, 0);
        check({name, "_full"}, full_m, full_exp);
        check({name, "_missing_commits"}, sb_m.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && commit_m === 1'b1) commits_m++;
    end

    initial begin : mon_m
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && commit_m === 1'b1) begin
                if (sb_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit_m: got commit at note_count=%0d, expected none", note_count_m);
                end else begin
                    e = sb_m.pop_front();
                    check("note_count_at_commit_m", note_count_m, e.idx + 1);
                    rd_addr = AW'(e.idx);
                    @(negedge clk);
                    checks++;
                    if (rd_key_m !== e.key || int'(rd_hold_m) != e.hold || int'(rd_period_m) != e.period) begin
                        errors++;
                        $display("FAIL entry_m%0d: got {%0d,%0d,%0d}, expected {%0d,%0d,%0d}", e.idx,
                                 rd_key_m, rd_hold_m, rd_period_m, e.key, e.hold, e.period);
                    end
                end
            end
        end
    end

    initial begin : mon_s
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && commit_s === 1'b1) begin
                if (sb_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit_s: got commit at note_count=%0d, expected none", note_count_s);
                end else begin
                    e = sb_s.pop_front();
                    rd_addr_s = AW'(e.idx);
                    @(negedge clk);
                    checks++;
                    if (rd_key_s !== e.key || int'(rd_hold_s) != e.hold || int'(rd_period_s) != e.period) begin
                        errors++;
                        $display("FAIL entry_s%0d: got {%0d,%0d,%0d}, expected {%0d,%0d,%0d}", e.idx,
                                 rd_key_s, rd_hold_s, rd_period_s, e.key, e.hold, e.period);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin : stim
        exp_t e;
        rst = 1'b1; rec_en = 1'b0; rec_en_s = 1'b0; key_on = 1'b0; key = 4'd0;
        cyc(3);
        check("reset_rd_key", rd_key_m, 0);
        check("reset_rd_hold", rd_hold_m, 0);
        check("reset_rd_period", rd_period_m, 0);
        check("reset_note_count", note_count_m, 0);
        check("reset_busy", busy_m, 0);
        check("reset_full", full_m, 0);
        check("reset_commit", commit_m, 0);
        rst = 1'b0;
        cyc(2);

        // Basic capture
        push_m(4'd4, 50, 100, 0);
        push_m(4'd2, 100, 120, 1);
        start_rec();
        play(4'd4, 50, 50);
        play(4'd2, 100, 20);
        rec_en = 1'b0;
        end_test("basic", 2, 0);

        // Legato key change
        push_m(4'd7, 30, 30, 0);
        push_m(4'd9, 40, 50, 1);
        start_rec();
        key = 4'd7; key_on = 1'b1;
        cyc(30);
        key = 4'd9;
        cyc(40);
        key_on = 1'b0;
        cyc(10);
        rec_en = 1'b0;
        end_test("legato", 2, 0);

        // Full: six notes into four entries
        commits_m = 0;
        start_rec();
        for (int i = 0; i < 4; i++) push_m(4'(i + 1), 12, 20, i);
        for (int i = 0; i < 6; i++) play(4'(i + 1), 12, 8);
        check("full_while_rec_high", full_m, 1);
        check("busy_after_full", busy_m, 0);
        rec_en = 1'b0;
        end_test("full", 4, 1);
        check("full_commit_pulses", commits_m, 4);

        // Short blip inside a gap
`ifdef SONG_REC_MIN_FILTER_EN
        push_m(4'd5, 20, 45, 0);
        push_m(4'd3, 15, 20, 1);
`else
        push_m(4'd5, 20, 30, 0);
        push_m(4'd8, 3, 15, 1);
        push_m(4'd3, 15, 20, 2);
`endif
        start_rec();
        play(4'd5, 20, 10);
        play(4'd8, 3, 12);
        play(4'd3, 15, 5);
        rec_en = 1'b0;
`ifdef SONG_REC_MIN_FILTER_EN
        end_test("blip", 2, 0);
`else
        end_test("blip", 3, 0);
`endif

        // Saturation on the narrow instance
        e.key = 4'd11; e.hold = 63; e.period = 63; e.idx = 0;
        sb_s.push_back(e);
        rec_en_s = 1'b1;
        cyc(2);
        key = 4'd11; key_on = 1'b1;
        cyc(100);
        key_on = 1'b0;
        cyc(10);
        rec_en_s = 1'b0;
        cyc(6);
        check("sat_note_count", note_count_s, 1);
        check("sat_busy", busy_s, 0);
        check("sat_missing_commits", sb_s.size(), 0);

        // Reset while a note is held
        push_m(4'd9, 10, 20, 0);
        start_rec();
        play(4'd9, 10, 10);
        key = 4'd6; key_on = 1'b1;
        cyc(20);
        check("pre_reset_note_count", note_count_m, 1);
        check("pre_reset_busy", busy_m, 1);
        rst = 1'b1;
        #1;
        check("midrst_rd_key", rd_key_m, 0);
        check("midrst_rd_hold", rd_hold_m, 0);
        check("midrst_rd_period", rd_period_m, 0);
        check("midrst_note_count", note_count_m, 0);
        check("midrst_busy", busy_m, 0);
        check("midrst_full", full_m, 0);
        check("midrst_commit", commit_m, 0);
        rec_en = 1'b0; key_on = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("post_reset_idle", busy_m, 0);
        push_m(4'd10, 12, 20, 0);
        start_rec();
        play(4'd10, 12, 8);
        rec_en = 1'b0;
        end_test("after_reset", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
# song_recorder

Captures a live note stream (key_on strobe plus 4-bit key code, the same encoding the song players emit) and records it as a sequence of note entries (key, hold cycles, onset-to-onset period cycles) into an internal memory. Sits between the keyboard/key scanner and the playback logic. A later player can replay a user-performed tune with its original timing through the registered read port.

## Interface
- DEPTH, 32: number of note entries stored.
- DUR_W, 26: width of hold/period fields; 26 bits covers more than 0.6 s at 100 MHz.
- MIN_HOLD, 1_000_000: minimum hold in cycles; used only when the filter macro is defined.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rec_en  in  1  level; rising edge starts a new recording, falling edge ends it.
- key_on  in  1  note gate, synchronous to clk.
- key  in  4  note code, valid while key_on is high.
- rd_addr  in  $clog2(DEPTH)  read index.
- rd_key  out  4  stored key at rd_addr.
- rd_hold  out  DUR_W  stored hold length.
- rd_period  out  DUR_W  stored onset-to-onset length.
- note_count  out  $clog2(DEPTH)+1  entries committed in current/last recording.
- busy  out  1  high in any state other than IDLE.
- full  out  1  note_count == DEPTH.
- commit  out  1  one-cycle pulse on each entry write.

## Operation
- FSM states:
  - IDLE: waits for a rec_en rise. On the rise: note_count←0, full←0, go to ARMED.
  - ARMED: waits for the first onset (key_on high, previous key_on low). On onset: latch key, cnt←1, go to HOLD.
  - HOLD: cnt increments.
    - key_on low: hold←cnt, go to GAP.
    - key_on still high but key differs from the latched key: this is a new onset. Commit (latched key, hold=cnt, period=cnt), latch the new key, cnt←1.
  - GAP: cnt increments. On onset: commit (key, hold, period=cnt), latch the new key, cnt←1, go to HOLD.
- A rec_en fall in HOLD or GAP commits the pending note. Period=cnt; hold=cnt if in HOLD, else the latched hold. Then go to IDLE. A rec_en fall in ARMED goes to IDLE with no commit.
- Counter arithmetic: cnt saturates at 2^DUR_W−1 and never wraps. Hold and period inherit the saturated value.
- Full handling: after the commit that makes note_count==DEPTH, go to IDLE. full stays high until the next rec_en rise. No commit occurs while full.
- Simultaneous events: a rec_en fall takes priority over an onset in the same cycle. That onset is ignored.
- rec_en rising while not in IDLE has no effect.
- Memory contents are not cleared by reset or by a new recording. Only entries below note_count are valid.

## Timing
- Reset values: rd_key=0, rd_hold=0, rd_period=0, note_count=0, busy=0, full=0, commit=0. FSM goes to IDLE and cnt to 0.
- Onset detection:
  - Onset is detected in the first cycle key_on is sampled high.
  - If onsets occur at cycles t1 and t2, the stored period = t2−t1.
  - If key_on first samples low at cycle tf, the stored hold = tf−t1.
- commit is asserted in the cycle after the detecting edge. The memory write and the note_count increment happen on that same edge.
- Read port: rd_* is registered from rd_addr with 1-cycle latency. Read-during-write to the same address returns the old data.
- busy rises one cycle after the rec_en rise is sampled.

## Configuration
- SONG_REC_MIN_FILTER_EN defined: a note whose hold < MIN_HOLD is discarded as a glitch. No commit occurs, and its cycles are added to the previous entry's pending period, so the timeline is preserved.
- SONG_REC_MIN_FILTER_EN undefined: every onset is committed and MIN_HOLD is unused.

## Structure
- Shared package piano_pkg:
  - NOTE_W=4.
  - Key code constants (the C..B encoding shared with the song players).
  - Packed struct note_entry_t {key, hold, period}, parameterised by DUR_W through a package localparam default.
  - FSM state enum for this block.
- Sub-module rec_mem: simple dual-port synchronous RAM of note_entry_t, one write port and one registered read port, DEPTH entries.

## Test plan
- Basic capture:
  - Stimulus: rec_en rise; key=4 high for 50 cycles, low for 50; key=2 high for 100, low for 20; then rec_en fall.
  - Response: note_count=2. Entry0={4,50,100}; entry1={2,100,120}.
- Legato key change:
  - Stimulus: key_on held high; key changes from 7 to 9 after 30 cycles; key_on falls 40 cycles later; rec_en falls 10 cycles after that.
  - Response: entry0={7,30,30}, entry1={9,40,50}.
- Full:
  - Stimulus: DEPTH=4, six notes played.
  - Response: commit pulses exactly 4 times, full=1, busy=0, and the 5th/6th notes are absent.
- Saturation:
  - Stimulus: DUR_W=6; a note held 100 cycles.
  - Response: hold=63 and period=63, with no wrap.
- Reset mid-HOLD:
  - Stimulus: assert rst while a note is held.
  - Response: all outputs at reset values immediately; after release, the state is IDLE and a new rec_en rise records normally.
- Filter:
  - Stimulus: with SONG_REC_MIN_FILTER_EN and MIN_HOLD=10, a 3-cycle blip inside a gap.
  - Response: no entry is committed for the blip, and the previous entry's period includes the blip's cycles.
  - Without the macro, the same stimulus commits the blip as its own entry.
